// File: rtl/ex_iter_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional EX_DIV_ZERO_FASTPATH_EN: a zero divisor skips CALC and goes straight to FIX.

module add_and_subtract #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         subtract,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] full;

  // subtract: a + ~b + 1, so cout=1 means a >= b (unsigned)
  assign full = {1'b0, a} + {1'b0, b ^ {W{subtract}}} + {{W{1'b0}}, subtract};
  assign sum  = full[W-1:0];
  assign cout = full[W];
endmodule

module ex_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       sa;
    logic       sb;
  } ctx_t;

  state_t           state_q, state_d;
  ctx_t             ctx_q, ctx_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   p, diff;
  logic             cout;
  logic [WIDTH-1:0] quot, rem;
  logic             unused_bits;

  assign p = {r_q, q_q[WIDTH-1]};

  add_and_subtract #(.W(WIDTH+1)) u_sub (
    .a        (p),
    .b        ({1'b0, mb_q}),
    .subtract (1'b1),
    .sum      (diff),
    .cout     (cout)
  );

  // diff[WIDTH] is always 0 when cout=1 since P < 2*divisor holds throughout
  assign unused_bits = ^{diff[WIDTH], ctx_q.op[0]};

  always_comb begin
    quot = (ctx_q.sa ^ ctx_q.sb) ? -q_q : q_q;
    rem  = ctx_q.sa ? -r_q : r_q;
    if (mb_q == '0) begin
      quot = '1;
      rem  = dvd_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    mb_d     = mb_q;
    r_d      = r_q;
    q_d      = q_q;
    dvd_d    = dvd_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          ctx_d.op = op;
          ctx_d.sa = ~op[0] & dividend[WIDTH-1];
          ctx_d.sb = ~op[0] & divisor[WIDTH-1];
          q_d      = ctx_d.sa ? -dividend : dividend;
          mb_d     = ctx_d.sb ? -divisor : divisor;
          r_d      = '0;
          cnt_d    = '0;
          dvd_d    = dividend;
          busy_d   = 1'b1;
          state_d  = CALC;
`ifdef EX_DIV_ZERO_FASTPATH_EN
          if (divisor == '0) state_d = FIX;
`endif
        end
      end
      CALC: begin
        r_d   = cout ? diff[WIDTH-1:0] : p[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], cout};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        result_d = ctx_q.op[1] ? rem : quot;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctx_q    <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      q_q      <= q_d;
      dvd_q    <= dvd_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_ex_iter_divider.sv
// Scoreboard bench for ex_iter_divider: directed vectors, monitor checks result and done cycle.
module tb_ex_iter_divider;
  localparam int W = 32;
`ifdef EX_DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] result;

  ex_iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, result %h (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", W'(cyc), W'(e.at));
      end
    end
  end

  // Waits for busy=0 at a drive point, then issues one op; returns in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input int lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    op = o; dividend = a; divisor = b; start = 1'b1;
    sb.push_back('{exp_res, cyc + lat});
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    chk("busy_cycle1", W'(busy), W'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    #12;
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_result", result, '0);
    @(negedge clk) rst_n = 1'b1;

    issue(DIVU, 32'd100, 32'd7, 32'd14, 34);
    issue(REMU, 32'd100, 32'd7, 32'd2, 34);
    issue(DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    issue(REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    issue(DIV,  32'h80000005, 32'd0, 32'hFFFFFFFF, ZLAT);
    issue(DIVU, 32'h80000005, 32'd0, 32'hFFFFFFFF, ZLAT);
    issue(REM,  32'h80000005, 32'd0, 32'h80000005, ZLAT);
    issue(REMU, 32'h80000005, 32'd0, 32'h80000005, ZLAT);
    issue(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    issue(REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
    issue(DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    issue(REM,  32'd7, 32'hFFFFFFFE, 32'd1, 34);
    issue(DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
    issue(REMU, 32'hFFFFFFFF, 32'h10, 32'hF, 34);
    drain();

    // kill in cycle 10, restart in cycle 11; last completed result was 0xF
    @(posedge clk); #1;
    c0 = cyc;
    op = DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", W'(busy), W'(0));
    chk("kill_result_held", result, 32'hF);
    op = DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    sb.push_back('{32'd10, c0 + 45});
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // start pulses at cycles 5 and 20 must be ignored
    @(posedge clk); #1;
    c0 = cyc;
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    sb.push_back('{32'd14, c0 + 34});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op = DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    op = REMU; dividend = 32'd9; divisor = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (40) @(posedge clk);

    // reset asserted in cycle 15 of an op
    #1;
    op = DIVU; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("rst_no_done_result", result, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
